fwd_ctrl: RTL and testbench

Forwarding and load-use hazard controller for the 5-stage pipeline. It tracks the destination register of every in-flight instruction in internal EX/MEM/WB shadow slots. From those slots it generates the 2-bit select codes that drive the two operand-forwarding 3:1 muxes at the EX stage. It also raises a load-use stall toward the fetch/decode pipeline registers.

---
 rtl/fwd_pkg.sv | 22 ++
 rtl/fwd_match.sv | 18 +
 rtl/fwd_ctrl.sv | 114 +++++++++++
 tb/tb_fwd_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared types and constants for the forwarding/hazard controller
package fwd_pkg;

    localparam int SLOT_REG_W = 5;
    localparam logic [SLOT_REG_W-1:0] XZR_IDX = 5'd31;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [SLOT_REG_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - one source-index vs one shadow-slot producer comparator
module fwd_match
    import fwd_pkg::*;
#(
    parameter int          REG_W = 5,
    parameter int unsigned XZR   = 31
) (
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  slot_t            slot,
    output logic             match
);

    // The zero register is never a real dependency, and an unread source cannot hazard.
    assign match = slot.valid & slot.regwrite & use_src &
                   (slot.rd == src) & (src != REG_W'(XZR));

endmodule

// File: rtl/fwd_ctrl.sv
// rtl/fwd_ctrl.sv - EX-stage forwarding selects and load-use stall (option: LOAD_USE_STALL_EN)
module fwd_ctrl
    import fwd_pkg::*;
#(
    parameter int          REG_W = 5,
    parameter int unsigned XZR   = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src_a,
    input  logic [REG_W-1:0] id_src_b,
    input  logic             id_use_a,
    input  logic             id_use_b,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall
);

    slot_t    ex_q, ex_d;
    slot_t    mem_q, mem_d;
    slot_t    wb_q, wb_d;
    fwd_sel_t fwd_a_q, fwd_a_d;
    fwd_sel_t fwd_b_q, fwd_b_d;

    logic match_ex_a, match_ex_b, match_mem_a, match_mem_b;
    logic bubble;
    logic ex_memread_in;

    fwd_match #(.REG_W(REG_W), .XZR(XZR)) u_match_ex_a (
        .src(id_src_a), .use_src(id_use_a), .slot(ex_q), .match(match_ex_a)
    );
    fwd_match #(.REG_W(REG_W), .XZR(XZR)) u_match_ex_b (
        .src(id_src_b), .use_src(id_use_b), .slot(ex_q), .match(match_ex_b)
    );
    fwd_match #(.REG_W(REG_W), .XZR(XZR)) u_match_mem_a (
        .src(id_src_a), .use_src(id_use_a), .slot(mem_q), .match(match_mem_a)
    );
    fwd_match #(.REG_W(REG_W), .XZR(XZR)) u_match_mem_b (
        .src(id_src_b), .use_src(id_use_b), .slot(mem_q), .match(match_mem_b)
    );

`ifdef LOAD_USE_STALL_EN
    // Load in EX feeding the instruction in ID: its data is not ready until MEM/WB.
    always_comb begin
        stall = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != SLOT_REG_W'(XZR)) &
                (match_ex_a | match_ex_b) & ~flush;
        ex_memread_in = id_memread;
    end
`else
    // Software schedules a NOP after every load, so no detection and no memread tracking.
    always_comb begin
        stall = 1'b0;
        ex_memread_in = 1'b0;
    end
`endif

    // WB slot is for debug visibility only; MEM/WB memread and the unused load flag are sinks.
    logic unused_sink;
    assign unused_sink = ^{wb_q, mem_q.memread, id_memread};

    // Advance the shadow pipeline and compute the registered mux selects for the ID instruction.
    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        bubble  = flush | stall | ~id_valid;
        if (!hold) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (bubble) begin
                ex_d    = SLOT_BUBBLE;
                fwd_a_d = FWD_REG;
                fwd_b_d = FWD_REG;
            end else begin
                ex_d.valid    = 1'b1;
                ex_d.rd       = SLOT_REG_W'(id_rd);
                ex_d.regwrite = id_regwrite;
                ex_d.memread  = ex_memread_in;
                // EX producer is the most recent writer, so it wins over MEM.
                fwd_a_d = match_ex_a ? FWD_EXMEM : (match_mem_a ? FWD_MEMWB : FWD_REG);
                fwd_b_d = match_ex_b ? FWD_EXMEM : (match_mem_b ? FWD_MEMWB : FWD_REG);
            end
        end
    end

    // State register; reset forgets every in-flight producer and wins over hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q    <= SLOT_BUBBLE;
            mem_q   <= SLOT_BUBBLE;
            wb_q    <= SLOT_BUBBLE;
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb/tb_fwd_ctrl.sv - directed self-checking bench for fwd_ctrl
module tb_fwd_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       hold;
    logic       flush;
    logic       id_valid;
    logic [4:0] id_src_a;
    logic [4:0] id_src_b;
    logic       id_use_a;
    logic       id_use_b;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_ctrl #(.REG_W(5), .XZR(31)) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_src_a(id_src_a), .id_src_b(id_src_b),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic ua,
                         input logic [4:0] b, input logic ub,
                         input logic [4:0] rd, input logic rw, input logic mr);
        id_valid = v; id_src_a = a; id_use_a = ua; id_src_b = b; id_use_b = ub;
        id_rd = rd; id_regwrite = rw; id_memread = mr;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; hold = 1'b0; flush = 1'b0;
        idle();
        step();
        step();
        reset = 1'b0;
        n_checks++; if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_a got %b want 00", fwd_a); end
        n_checks++; if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_b got %b want 00", fwd_b); end
        n_checks++; if (stall !== 1'b0)  begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    endtask

    task automatic test_back_to_back();
        drive(1, 5'd2, 1, 5'd3, 1, 5'd1, 1, 0);   // ADD X1,X2,X3
        step();
        drive(1, 5'd1, 1, 5'd5, 1, 5'd4, 1, 0);   // SUB X4,X1,X5
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got %b want 0", stall); end
        step();
        n_checks++; if (fwd_a !== 2'b01) begin n_fail++; $display("FAIL b2b_fwd_a got %b want 01", fwd_a); end
        n_checks++; if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL b2b_fwd_b got %b want 00", fwd_b); end
        drain();
    endtask

    task automatic test_mem_fwd();
        drive(1, 5'd2, 1, 5'd3, 1, 5'd1, 1, 0);   // ADD X1
        step();
        idle();                                   // NOP
        step();
        drive(1, 5'd7, 1, 5'd1, 1, 5'd6, 1, 0);   // ORR X6,X7,X1
        step();
        n_checks++; if (fwd_b !== 2'b10) begin n_fail++; $display("FAIL memfwd_fwd_b got %b want 10", fwd_b); end
        n_checks++; if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL memfwd_fwd_a got %b want 00", fwd_a); end
        drain();
    endtask

    task automatic test_priority();
        drive(1, 5'd2, 1, 5'd3, 1, 5'd1, 1, 0);   // ADD X1
        step();
        drive(1, 5'd2, 1, 5'd3, 1, 5'd1, 1, 0);   // ADD X1
        step();
        drive(1, 5'd1, 1, 5'd1, 1, 5'd2, 1, 0);   // SUB X2,X1,X1
        step();
        n_checks++; if (fwd_a !== 2'b01) begin n_fail++; $display("FAIL prio_fwd_a got %b want 01", fwd_a); end
        n_checks++; if (fwd_b !== 2'b01) begin n_fail++; $display("FAIL prio_fwd_b got %b want 01", fwd_b); end
        drain();
    endtask

    task automatic test_load_use();
        drive(1, 5'd0, 1, 5'd0, 0, 5'd9, 1, 1);   // LDUR X9,[X0]
        step();
        drive(1, 5'd9, 1, 5'd9, 1, 5'd3, 1, 0);   // ADD X3,X9,X9
`ifdef LOAD_USE_STALL_EN
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b want 1", stall); end
        step();
        n_checks++; if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL lu_bubble_fwd_a got %b want 00", fwd_a); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once got %b want 0", stall); end
        step();
        n_checks++; if (fwd_a !== 2'b10) begin n_fail++; $display("FAIL lu_retry_fwd_a got %b want 10", fwd_a); end
        n_checks++; if (fwd_b !== 2'b10) begin n_fail++; $display("FAIL lu_retry_fwd_b got %b want 10", fwd_b); end
`else
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_nostall got %b want 0", stall); end
        step();
        n_checks++; if (fwd_a !== 2'b01) begin n_fail++; $display("FAIL lu_stale_fwd_a got %b want 01", fwd_a); end
        n_checks++; if (fwd_b !== 2'b01) begin n_fail++; $display("FAIL lu_stale_fwd_b got %b want 01", fwd_b); end
`endif
        drain();
    endtask

    task automatic test_xzr();
        drive(1, 5'd1, 1, 5'd2, 1, 5'd31, 1, 0);  // ADD XZR,X1,X2
        step();
        drive(1, 5'd31, 1, 5'd4, 1, 5'd3, 1, 0);  // SUB X3,XZR,X4
        step();
        n_checks++; if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL xzr_fwd_a got %b want 00", fwd_a); end
        drain();
        drive(1, 5'd0, 1, 5'd0, 0, 5'd31, 1, 1);  // LDUR XZR
        step();
        drive(1, 5'd31, 1, 5'd31, 1, 5'd5, 1, 0); // ADD X5,XZR,XZR
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL xzr_stall got %b want 0", stall); end
        step();
        n_checks++; if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL xzr_load_fwd_b got %b want 00", fwd_b); end
        drain();
    endtask

    task automatic test_flush();
        drive(1, 5'd0, 1, 5'd0, 0, 5'd9, 1, 1);   // LDUR X9
        step();
        flush = 1'b1;
        drive(1, 5'd9, 1, 5'd9, 1, 5'd3, 1, 0);   // ADD X3,X9,X9 squashed
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b want 0", stall); end
        step();
        flush = 1'b0;
        n_checks++; if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL flush_fwd_a got %b want 00", fwd_a); end
        n_checks++; if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL flush_fwd_b got %b want 00", fwd_b); end
        drain();
    endtask

    task automatic test_hold();
        drive(1, 5'd2, 1, 5'd3, 1, 5'd1, 1, 0);   // ADD X1
        step();
        drive(1, 5'd1, 1, 5'd5, 1, 5'd4, 1, 0);   // SUB X4,X1,X5
        step();
        hold = 1'b1;
        drive(1, 5'd1, 1, 5'd4, 1, 5'd7, 1, 0);   // ORR X7,X1,X4 waiting in ID
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (fwd_a !== 2'b01) begin n_fail++; $display("FAIL hold_fwd_a[%0d] got %b want 01", i, fwd_a); end
            n_checks++; if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL hold_fwd_b[%0d] got %b want 00", i, fwd_b); end
        end
        hold = 1'b0;
        #1;
        step();
        n_checks++; if (fwd_a !== 2'b10) begin n_fail++; $display("FAIL resume_fwd_a got %b want 10", fwd_a); end
        n_checks++; if (fwd_b !== 2'b01) begin n_fail++; $display("FAIL resume_fwd_b got %b want 01", fwd_b); end
        drain();
    endtask

    task automatic test_reset_mid();
        drive(1, 5'd2, 1, 5'd3, 1, 5'd1, 1, 0);   // ADD X1
        step();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
        drive(1, 5'd1, 1, 5'd5, 1, 5'd4, 1, 0);   // SUB X4,X1,X5
        step();
        n_checks++; if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL rstmid_fwd_a got %b want 00", fwd_a); end
        drain();
        drive(1, 5'd2, 1, 5'd3, 1, 5'd1, 1, 0);   // ADD X1
        step();
        drive(1, 5'd1, 1, 5'd5, 1, 5'd4, 1, 0);   // SUB X4,X1,X5
        step();
        n_checks++; if (fwd_a !== 2'b01) begin n_fail++; $display("FAIL prehold_fwd_a got %b want 01", fwd_a); end
        hold = 1'b1; reset = 1'b1;
        #1;
        step();
        hold = 1'b0; reset = 1'b0;
        n_checks++; if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL holdrst_fwd_a got %b want 00", fwd_a); end
        drain();
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; flush = 1'b0;
        idle();
        test_reset();
        test_back_to_back();
        test_mem_fwd();
        test_priority();
        test_load_use();
        test_xzr();
        test_flush();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
